// File: rtl/min_counter_bcd.sv
// Minutes stage of the irrigation timer: two-digit BCD minute count driven by the
// falling edge of the tens-of-seconds carry, plus an IDLE/RUN/DONE valve controller.
module min_counter_bcd #(
    parameter logic [7:0] DEFAULT_DUR = 8'h05,
    parameter int         MAX_TENS    = 5
) (
    input  logic       i_clk,
    input  logic       i_pulse,
    input  logic       i_sec_carry,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_load,
    input  logic [7:0] i_dur_bcd,
    output logic [3:0] o_min_units,
    output logic [3:0] o_min_tens,
    output logic       o_carry_out,
    output logic       o_valve_on,
    output logic       o_done,
    output logic       o_dur_err,
    output logic [1:0] o_state,
    output logic [7:0] o_dur_reg
);

    localparam logic [3:0] LP_MAX_TENS = 4'(MAX_TENS);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_carry_prev;
    logic [3:0] r_units;
    logic [3:0] r_tens;
    logic       r_carry_out;
    logic       r_valve_on;
    logic       r_done;
    logic       r_dur_err;
    logic [7:0] r_dur;

    logic       w_tick;
    logic       w_load_ok;
    logic [7:0] w_dur_eff;
    logic       w_wrap;
    logic [3:0] w_inc_units;
    logic [3:0] w_inc_tens;
    logic [3:0] w_units_nxt;
    logic [3:0] w_tens_nxt;
    logic       w_carry_nxt;

    // Falling edge of the upstream carry marks the seconds 59->00 boundary.
    assign w_tick    = r_carry_prev & ~i_sec_carry;
    assign w_load_ok = i_load && (i_dur_bcd[3:0] <= 4'd9) && (i_dur_bcd[7:4] <= LP_MAX_TENS);
    // A start in the same cycle as a valid load runs against the new duration.
    assign w_dur_eff = w_load_ok ? i_dur_bcd : r_dur;

    always_comb begin
        w_wrap      = (r_units >= 4'd9) && (r_tens >= LP_MAX_TENS);
        w_inc_units = r_units + 4'd1;
        w_inc_tens  = r_tens;
        if (w_wrap) begin
            w_inc_units = 4'd0;
            w_inc_tens  = 4'd0;
        end else if (r_units >= 4'd9) begin
            w_inc_units = 4'd0;
            w_inc_tens  = r_tens + 4'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_units_nxt = r_units;
        w_tens_nxt  = r_tens;
        w_carry_nxt = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_units_nxt = 4'd0;
                    w_tens_nxt  = 4'd0;
                    w_state_nxt = (w_dur_eff == 8'h00) ? S_DONE : S_RUN;
                end else if (i_stop) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (i_stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tick) begin
                    w_units_nxt = w_inc_units;
                    w_tens_nxt  = w_inc_tens;
                    w_carry_nxt = w_wrap;
                    if ({w_inc_tens, w_inc_units} == r_dur) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_pulse) begin
            r_state      <= S_IDLE;
            r_carry_prev <= 1'b0;
            r_units      <= 4'd0;
            r_tens       <= 4'd0;
            r_carry_out  <= 1'b0;
            r_valve_on   <= 1'b0;
            r_done       <= 1'b0;
            r_dur_err    <= 1'b0;
            r_dur        <= DEFAULT_DUR;
        end else begin
            r_state      <= w_state_nxt;
            r_carry_prev <= i_sec_carry;
            r_units      <= w_units_nxt;
            r_tens       <= w_tens_nxt;
            r_carry_out  <= w_carry_nxt;
            r_valve_on   <= (w_state_nxt == S_RUN);
            r_done       <= (w_state_nxt == S_DONE);
            r_dur_err    <= i_load && !w_load_ok;
            if (w_load_ok) begin
                r_dur <= i_dur_bcd;
            end
        end
    end

    assign o_min_units = r_units;
    assign o_min_tens  = r_tens;
    assign o_carry_out = r_carry_out;
    assign o_valve_on  = r_valve_on;
    assign o_done      = r_done;
    assign o_dur_err   = r_dur_err;
    assign o_state     = r_state;
    assign o_dur_reg   = r_dur;

endmodule

// File: tb/tb_min_counter_bcd.sv
// Directed bench for min_counter_bcd: reset, duration runs, load rejection,
// wrap with carry_out, stop/tick collision and mid-run reset.
module tb_min_counter_bcd;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    logic       clk = 1'b0;
    logic       pulse = 1'b0;
    logic       sec_carry = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       load = 1'b0;
    logic [7:0] dur_bcd = 8'h00;
    logic [3:0] min_units;
    logic [3:0] min_tens;
    logic       carry_out;
    logic       valve_on;
    logic       done;
    logic       dur_err;
    logic [1:0] state;
    logic [7:0] dur_reg;

    int n_cmp = 0;
    int n_err = 0;

    min_counter_bcd dut (
        .i_clk       (clk),
        .i_pulse     (pulse),
        .i_sec_carry (sec_carry),
        .i_start     (start),
        .i_stop      (stop),
        .i_load      (load),
        .i_dur_bcd   (dur_bcd),
        .o_min_units (min_units),
        .o_min_tens  (min_tens),
        .o_carry_out (carry_out),
        .o_valve_on  (valve_on),
        .o_done      (done),
        .o_dur_err   (dur_err),
        .o_state     (state),
        .o_dur_reg   (dur_reg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Carry high for hi cycles, then low for the one edge that registers the tick.
    task automatic minute_tick(input int hi);
        sec_carry = 1'b1;
        repeat (hi) cyc();
        sec_carry = 1'b0;
        cyc();
    endtask

    function automatic logic [7:0] bcd(input int k);
        logic [7:0] b;
        b[7:4] = 4'(k / 10);
        b[3:0] = 4'(k % 10);
        return b;
    endfunction

    function automatic logic [7:0] count();
        return {min_tens, min_units};
    endfunction

    initial begin
        // Reset, then idle
        pulse = 1'b1;
        cyc();
        pulse = 1'b0;
        repeat (5) cyc();
        check_eq("rst_count", 32'(count()), 32'h00);
        check_eq("rst_valve", 32'(valve_on), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_carry", 32'(carry_out), 32'd0);
        check_eq("rst_err", 32'(dur_err), 32'd0);
        check_eq("rst_state", 32'(state), 32'(ST_IDLE));
        check_eq("rst_dur", 32'(dur_reg), 32'h05);

        // Duration 3 run, carry high 10 cycles per minute
        load = 1'b1; dur_bcd = 8'h03;
        cyc();
        load = 1'b0;
        check_eq("load3_dur", 32'(dur_reg), 32'h03);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check_eq("run3_valve", 32'(valve_on), 32'd1);
        check_eq("run3_state", 32'(state), 32'(ST_RUN));
        for (int k = 1; k <= 3; k++) begin
            sec_carry = 1'b1;
            repeat (10) cyc();
            check_eq("run3_hold_hi", 32'(count()), 32'(bcd(k - 1)));
            sec_carry = 1'b0;
            cyc();
            check_eq("run3_tick", 32'(count()), 32'(bcd(k)));
        end
        check_eq("run3_done", 32'(done), 32'd1);
        check_eq("run3_valve_off", 32'(valve_on), 32'd0);
        minute_tick(2);
        check_eq("done_hold", 32'(count()), 32'h03);

        // Rejected loads
        load = 1'b1; dur_bcd = 8'h60;
        cyc();
        load = 1'b0;
        check_eq("bad60_err", 32'(dur_err), 32'd1);
        check_eq("bad60_dur", 32'(dur_reg), 32'h03);
        cyc();
        check_eq("bad60_err_clr", 32'(dur_err), 32'd0);
        load = 1'b1; dur_bcd = 8'h1A;
        cyc();
        load = 1'b0;
        check_eq("bad1A_err", 32'(dur_err), 32'd1);
        check_eq("bad1A_dur", 32'(dur_reg), 32'h03);
        cyc();
        check_eq("bad1A_err_clr", 32'(dur_err), 32'd0);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check_eq("ack_idle", 32'(state), 32'(ST_IDLE));

        // Zero duration load + start together goes straight to DONE
        load = 1'b1; dur_bcd = 8'h00; start = 1'b1;
        cyc();
        load = 1'b0; start = 1'b0;
        check_eq("zero_state", 32'(state), 32'(ST_DONE));
        check_eq("zero_done", 32'(done), 32'd1);
        check_eq("zero_count", 32'(count()), 32'h00);
        check_eq("zero_valve", 32'(valve_on), 32'd0);

        // Duration 59 from DONE (start restarts)
        load = 1'b1; dur_bcd = 8'h59; start = 1'b1;
        cyc();
        load = 1'b0; start = 1'b0;
        check_eq("d59_state", 32'(state), 32'(ST_RUN));
        for (int k = 1; k <= 59; k++) begin
            minute_tick(1);
            check_eq("d59_count", 32'(count()), 32'(bcd(k)));
        end
        check_eq("d59_done", 32'(done), 32'd1);
        check_eq("d59_carry", 32'(carry_out), 32'd0);

        // Wrap: shrink duration at 58 so the run crosses 59->00
        start = 1'b1;
        cyc();
        start = 1'b0;
        check_eq("wrap_start", 32'(count()), 32'h00);
        for (int k = 1; k <= 58; k++) minute_tick(1);
        check_eq("wrap_58", 32'(count()), 32'h58);
        load = 1'b1; dur_bcd = 8'h05;
        cyc();
        load = 1'b0;
        minute_tick(1);
        check_eq("wrap_59", 32'(count()), 32'h59);
        check_eq("wrap_59_state", 32'(state), 32'(ST_RUN));
        minute_tick(1);
        check_eq("wrap_00", 32'(count()), 32'h00);
        check_eq("wrap_carry", 32'(carry_out), 32'd1);
        check_eq("wrap_still_run", 32'(state), 32'(ST_RUN));
        cyc();
        check_eq("wrap_carry_clr", 32'(carry_out), 32'd0);
        for (int k = 1; k <= 5; k++) minute_tick(1);
        check_eq("wrap_end", 32'(count()), 32'h05);
        check_eq("wrap_done", 32'(done), 32'd1);

        // Stop coincident with a tick at 12
        load = 1'b1; dur_bcd = 8'h30; start = 1'b1;
        cyc();
        load = 1'b0; start = 1'b0;
        for (int k = 1; k <= 12; k++) minute_tick(1);
        check_eq("stop_pre", 32'(count()), 32'h12);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check_eq("start_in_run_state", 32'(state), 32'(ST_RUN));
        check_eq("start_in_run_count", 32'(count()), 32'h12);
        sec_carry = 1'b1;
        cyc();
        sec_carry = 1'b0; stop = 1'b1;
        cyc();
        stop = 1'b0;
        check_eq("stop_state", 32'(state), 32'(ST_IDLE));
        check_eq("stop_count", 32'(count()), 32'h12);
        check_eq("stop_valve", 32'(valve_on), 32'd0);
        minute_tick(2);
        check_eq("idle_tick_count", 32'(count()), 32'h12);

        // Reset during RUN at 07 with start and a tick in the same cycle
        start = 1'b1;
        cyc();
        start = 1'b0;
        check_eq("r7_start", 32'(count()), 32'h00);
        for (int k = 1; k <= 7; k++) minute_tick(1);
        check_eq("r7_count", 32'(count()), 32'h07);
        sec_carry = 1'b1;
        cyc();
        sec_carry = 1'b0; start = 1'b1; pulse = 1'b1;
        cyc();
        start = 1'b0; pulse = 1'b0;
        check_eq("r7_count_rst", 32'(count()), 32'h00);
        check_eq("r7_valve", 32'(valve_on), 32'd0);
        check_eq("r7_done", 32'(done), 32'd0);
        check_eq("r7_carry", 32'(carry_out), 32'd0);
        check_eq("r7_state", 32'(state), 32'(ST_IDLE));
        check_eq("r7_dur", 32'(dur_reg), 32'h05);
        cyc();
        check_eq("r7_after", 32'(state), 32'(ST_IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/min_counter_bcd.md
Name: min_counter_bcd

Overview:
- Minutes stage placed directly downstream of the tens-of-seconds counter; consumes its carry level and keeps a two-digit BCD minute count (00–59).
- Holds a programmable irrigation duration in BCD minutes and runs a small IDLE/RUN/DONE machine.
- Asserts valve_on for the whole run and raises done when the elapsed minutes equal the duration.
- Synchronous single-clock design: the upstream carry is an enable, never a clock.

Parameters:
- DEFAULT_DUR, 8'h05: reset value of the duration register, packed BCD {tens, units}.
- MAX_TENS, 5: highest legal tens digit; the count wraps after MAX_TENS9.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- pulse  input  1  synchronous reset, active-high.
- sec_carry  input  1  carry level from the tens-of-seconds stage; high while that digit is 5 (seconds 50–59).
- start  input  1  one-cycle request to begin a run.
- stop  input  1  one-cycle request to abort a run or acknowledge DONE.
- load  input  1  one-cycle strobe: capture dur_bcd.
- dur_bcd  input  8  requested duration in packed BCD, {tens[7:4], units[3:0]}.
- min_units  output  4  BCD minute units digit.
- min_tens  output  4  BCD minute tens digit.
- carry_out  output  1  one-cycle pulse on the 59->00 wrap, for a future hours stage.
- valve_on  output  1  high while state is RUN.
- done  output  1  high while state is DONE.
- dur_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (pulse=1 at a clock edge): min_units=0, min_tens=0, carry_out=0, valve_on=0, done=0, dur_err=0, state=IDLE, dur_reg=DEFAULT_DUR, carry_prev=0.
- pulse overrides every other input in the same cycle, including mid-run; the valve closes on that edge.
- All outputs are registered. carry_out and dur_err return to 0 on the cycle after any pulse.
- Tick detection:
  - carry_prev <= sec_carry every cycle.
  - tick = carry_prev & ~sec_carry, i.e. the falling edge of the carry, which is the seconds 59->00 boundary.
  - The count changes on the first clock edge at which sec_carry is sampled low after being high: 1-cycle latency.
  - A carry held high indefinitely produces no tick.
- BCD increment:
  - units 0–8: units+1.
  - units 9: units=0 and tens+1.
  - At MAX_TENS:9 the count becomes 00 and carry_out pulses 1 cycle.
  - Digits never leave the 0–9 range, and tens never exceeds MAX_TENS.
- Load:
  - Accepted in any state.
  - dur_reg <= dur_bcd only if units<=9 and tens<=MAX_TENS.
  - Otherwise dur_reg is unchanged and dur_err pulses.
- IDLE:
  - Ticks are ignored and the count holds.
  - start=1 -> count cleared to 00, state RUN.
  - If dur_reg==00, the state goes to DONE instead of RUN.
  - If load and start arrive in the same cycle, the new duration is used (compare against dur_bcd when it is valid).
- RUN:
  - On a tick, increment the count. If the incremented value equals dur_reg, state goes to DONE on the same edge; count shows the final value.
  - stop=1 -> IDLE, count retained (elapsed time visible).
  - If stop and a tick arrive in the same cycle, stop wins and there is no increment.
  - start while in RUN is ignored.
  - A load in RUN that shrinks dur_reg below the current count leaves the run going until the count wraps and reaches dur_reg again.
- DONE:
  - done=1, valve_on=0, ticks ignored, count held.
  - stop=1 -> IDLE.
  - start=1 -> count cleared to 00, new run (RUN).
  - If start and stop arrive in the same cycle, start wins.
- State encoding is free, with one constraint: an illegal state recovers to IDLE on the next edge.

Test Plan:
- Reset, then idle for 5 cycles -> outputs 00, valve_on=0, done=0, dur_reg=0x05.
- load dur_bcd=0x03, start, then three carry high(10 cycles)/low sequences -> valve_on=1 from the cycle after start; min_units 1, 2, 3, each changing 1 cycle after the carry falls; on the third, done=1 and valve_on=0.
- load 0x60 and load 0x1A -> dur_err pulses once per load, dur_reg stays 0x03; then load 0x00 + start -> DONE next cycle, count 00.
- Duration 0x59 with a start at count 00, then 59 ticks -> done at 59; restart and force 60 ticks with a large dur -> at 59->00 carry_out pulses exactly 1 cycle and min_tens goes 5->0.
- Mid-run at count 0x12: assert stop together with a carry falling edge -> IDLE, count stays 0x12; a later tick leaves the count unchanged.
- Assert pulse during RUN at 0x07, coincident with start and a tick -> all outputs 0, state IDLE, dur_reg=0x05 on the next cycle.
